// File: rtl/alu_issue_stage_if.sv
// Request bundle between the fetch/regfile side, the issue stage and EX.
// The issue stage uses the master view; the surrounding environment uses the slave view.
interface alu_issue_stage_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTR;
  logic [31:0] PC;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [4:0]  SELECT;
  logic        ILLEGAL;

  modport master (
    input  IN_VALID, INSTR, PC, RS1_DATA, RS2_DATA, OUT_READY,
    output IN_READY, OUT_VALID, DATA1, DATA2, SELECT, ILLEGAL
  );

  modport slave (
    output IN_VALID, INSTR, PC, RS1_DATA, RS2_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, DATA1, DATA2, SELECT, ILLEGAL
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32IM decode/issue stage: decodes, selects ALU operands and SELECT code, and
// holds multiply/divide requests back for MULDIV_CYCLES before offering them to EX.
module alu_issue_stage #(
  parameter int MULDIV_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  alu_issue_stage_if.master bus
);
  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] SEL_ADD  = 5'b00000;
  localparam logic [4:0] SEL_SUB  = 5'b00001;
  localparam logic [4:0] SEL_AND  = 5'b00010;
  localparam logic [4:0] SEL_OR   = 5'b00011;
  localparam logic [4:0] SEL_XOR  = 5'b00100;
  localparam logic [4:0] SEL_SLL  = 5'b00101;
  localparam logic [4:0] SEL_SRL  = 5'b00110;
  localparam logic [4:0] SEL_SRA  = 5'b00111;
  localparam logic [4:0] SEL_SLT  = 5'b10000;
  localparam logic [4:0] SEL_SLTU = 5'b10001;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  function automatic logic [4:0] base_select(input logic [2:0] f3);
    case (f3)
      3'b000:  base_select = SEL_ADD;
      3'b001:  base_select = SEL_SLL;
      3'b010:  base_select = SEL_SLT;
      3'b011:  base_select = SEL_SLTU;
      3'b100:  base_select = SEL_XOR;
      3'b101:  base_select = SEL_SRL;
      3'b110:  base_select = SEL_OR;
      default: base_select = SEL_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = bus.INSTR[6:0];
  assign funct3 = bus.INSTR[14:12];
  assign funct7 = bus.INSTR[31:25];
  assign imm_i  = {{20{bus.INSTR[31]}}, bus.INSTR[31:20]};
  assign imm_s  = {{20{bus.INSTR[31]}}, bus.INSTR[31:25], bus.INSTR[11:7]};
  assign imm_u  = {bus.INSTR[31:12], 12'b0};
  assign shamt  = {27'b0, bus.INSTR[24:20]};

  logic [31:0] dec_data1;
  logic [31:0] dec_data2;
  logic [4:0]  dec_select;
  logic        dec_illegal;
  logic        dec_muldiv;

  always_comb begin
    dec_illegal = 1'b1;
    dec_select  = SEL_ADD;
    dec_data1   = '0;
    dec_data2   = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          dec_illegal = 1'b0;
          dec_select  = base_select(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_illegal = 1'b0;
          dec_select  = SEL_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_illegal = 1'b0;
          dec_select  = SEL_SRA;
        end else if (funct7 == 7'b0000001) begin
          // funct3 matches the muldiv SELECT low bits except MULHSU/MULHU, which swap
          dec_illegal = 1'b0;
          dec_select  = {2'b01, funct3[2], funct3[1], funct3[0] ^ (funct3[1] & ~funct3[2])};
        end
        if (!dec_illegal) begin
          dec_data1 = bus.RS1_DATA;
          dec_data2 = bus.RS2_DATA;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) begin
            dec_illegal = 1'b0;
            dec_select  = SEL_SLL;
            dec_data2   = shamt;
          end
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000) begin
            dec_illegal = 1'b0;
            dec_select  = SEL_SRL;
            dec_data2   = shamt;
          end else if (funct7 == 7'b0100000) begin
            dec_illegal = 1'b0;
            dec_select  = SEL_SRA;
            dec_data2   = shamt;
          end
        end else begin
          dec_illegal = 1'b0;
          dec_select  = base_select(funct3);
          dec_data2   = imm_i;
        end
        if (!dec_illegal) begin
          dec_data1 = bus.RS1_DATA;
        end
      end
      OPC_LUI: begin
        dec_illegal = 1'b0;
        dec_data2   = imm_u;
      end
      OPC_AUIPC: begin
        dec_illegal = 1'b0;
        dec_data1   = bus.PC;
        dec_data2   = imm_u;
      end
      OPC_LOAD: begin
        dec_illegal = 1'b0;
        dec_data1   = bus.RS1_DATA;
        dec_data2   = imm_i;
      end
      OPC_STORE: begin
        dec_illegal = 1'b0;
        dec_data1   = bus.RS1_DATA;
        dec_data2   = imm_s;
      end
      OPC_BRANCH: begin
        dec_illegal = 1'b0;
        dec_select  = SEL_SUB;
        dec_data1   = bus.RS1_DATA;
        dec_data2   = bus.RS2_DATA;
      end
      default: begin
      end
    endcase
    dec_muldiv = !dec_illegal && (dec_select[4:3] == 2'b01);
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      data1_q, data1_d;
  logic [31:0]      data2_q, data2_d;
  logic [4:0]       select_q, select_d;
  logic             illegal_q, illegal_d;
  logic             in_ready;
  logic             accept;

  // Flush is applied last so it overrides any accept or WAIT countdown in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    select_d    = select_q;
    illegal_d   = illegal_q;
    in_ready    = 1'b0;
    accept      = 1'b0;

    case (state_q)
      S_EMPTY: begin
        in_ready = 1'b1;
        accept   = bus.IN_VALID;
      end
      S_WAIT: begin
        if (cnt_q == CNT_ONE || cnt_q == '0) begin
          state_d     = S_FULL;
          cnt_d       = '0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FULL: begin
        in_ready = bus.OUT_READY;
        if (bus.OUT_READY) begin
          if (bus.IN_VALID) begin
            accept = 1'b1;
          end else begin
            state_d     = S_EMPTY;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = S_EMPTY;
        out_valid_d = 1'b0;
      end
    endcase

    if (accept && !FLUSH) begin
      data1_d   = dec_data1;
      data2_d   = dec_data2;
      select_d  = dec_select;
      illegal_d = dec_illegal;
      if (dec_muldiv && MULDIV_CYCLES > 1) begin
        state_d     = S_WAIT;
        cnt_d       = CNT_LOAD;
        out_valid_d = 1'b0;
      end else begin
        state_d     = S_FULL;
        cnt_d       = '0;
        out_valid_d = 1'b1;
      end
    end

    if (FLUSH) begin
      state_d     = S_EMPTY;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      select_q    <= SEL_ADD;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      select_q    <= select_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.DATA1     = data1_q;
  assign bus.DATA2     = data2_q;
  assign bus.SELECT    = select_q;
  assign bus.ILLEGAL   = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vectors plus a transaction-level reference model
// that is compared against the DUT on every falling clock edge.
module tb_alu_issue_stage;
  localparam int MC = 3;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic FLUSH = 1'b0;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.MULDIV_CYCLES(MC)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .FLUSH (FLUSH),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  sel;
    logic        ill;
    logic        md;
  } exp_t;

  // Spec tables: base integer ops by funct3 and M-extension ops by funct3.
  localparam logic [4:0] BASE_TBL [8] = '{5'd0, 5'd5, 5'd16, 5'd17, 5'd4, 5'd6, 5'd3, 5'd2};
  localparam logic [4:0] MD_TBL   [8] = '{5'd8, 5'd9, 5'd11, 5'd10, 5'd12, 5'd13, 5'd14, 5'd15};

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_u;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_u = {ins[31:12], 12'h000};
    e = '0;
    e.ill = 1'b1;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) begin e.ill = 0; e.sel = BASE_TBL[f3]; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin e.ill = 0; e.sel = 5'd1; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 0; e.sel = 5'd7; end
        else if (f7 == 7'h01) begin e.ill = 0; e.sel = MD_TBL[f3]; end
        if (!e.ill) begin e.d1 = a; e.d2 = b; end
      end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (f7 == 7'h00) begin e.ill = 0; e.sel = BASE_TBL[f3]; end
          else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 0; e.sel = 5'd7; end
          if (!e.ill) e.d2 = {27'd0, ins[24:20]};
        end else begin
          e.ill = 0; e.sel = BASE_TBL[f3]; e.d2 = imm_i;
        end
        if (!e.ill) e.d1 = a;
      end
      7'h37: begin e.ill = 0; e.d2 = imm_u; end
      7'h17: begin e.ill = 0; e.d1 = pc; e.d2 = imm_u; end
      7'h03: begin e.ill = 0; e.d1 = a; e.d2 = imm_i; end
      7'h23: begin e.ill = 0; e.d1 = a; e.d2 = imm_s; end
      7'h63: begin e.ill = 0; e.sel = 5'd1; e.d1 = a; e.d2 = b; end
      default: ;
    endcase
    e.md = !e.ill && (e.sel >= 5'd8) && (e.sel <= 5'd15);
    return e;
  endfunction

  // Model: at most one held request, visible from edge index m_vis_at onward.
  bit   m_have   = 1'b0;
  int   m_cnt    = 0;
  int   m_vis_at = 0;
  exp_t m_item   = '0;
  bit   cmp_en   = 1'b0;

  function automatic bit m_visible();
    return m_have && (m_cnt >= m_vis_at);
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_have <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (FLUSH) begin
        m_have <= 1'b0;
      end else if (bus.IN_VALID && (!m_have || (m_visible() && bus.OUT_READY))) begin
        m_have   <= 1'b1;
        m_item   <= ref_decode(bus.INSTR, bus.PC, bus.RS1_DATA, bus.RS2_DATA);
        m_vis_at <= m_cnt + 1 +
                    (ref_decode(bus.INSTR, bus.PC, bus.RS1_DATA, bus.RS2_DATA).md ? MC - 1 : 0);
      end else if (m_visible() && bus.OUT_READY) begin
        m_have <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      if (!RESET) begin
        check_output("rst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check_output("rst_data1", bus.DATA1, 32'd0);
        check_output("rst_data2", bus.DATA2, 32'd0);
        check_output("rst_select", {27'd0, bus.SELECT}, 32'd0);
        check_output("rst_illegal", {31'd0, bus.ILLEGAL}, 32'd0);
      end else begin
        check_output("model_out_valid", {31'd0, bus.OUT_VALID}, {31'd0, m_visible()});
        check_output("model_in_ready", {31'd0, bus.IN_READY},
                     {31'd0, (!m_have || (m_visible() && bus.OUT_READY))});
        if (m_visible()) begin
          check_output("model_data1", bus.DATA1, m_item.d1);
          check_output("model_data2", bus.DATA2, m_item.d2);
          check_output("model_select", {27'd0, bus.SELECT}, {27'd0, m_item.sel});
          check_output("model_illegal", {31'd0, bus.ILLEGAL}, {31'd0, m_item.ill});
        end
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, input logic ordy, input logic fl);
    bus.IN_VALID  = v;
    bus.INSTR     = ins;
    bus.PC        = 32'h0000_0100;
    bus.RS1_DATA  = a;
    bus.RS2_DATA  = b;
    bus.OUT_READY = ordy;
    FLUSH         = fl;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  typedef struct { logic [31:0] ins; logic [31:0] pc; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t vecs[$];

  localparam logic [31:0] I_ADD   = 32'h003100B3;
  localparam logic [31:0] I_SUB   = 32'h403100B3;
  localparam logic [31:0] I_SRAI  = 32'h40415093;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_DIV   = 32'h023140B3;
  localparam logic [31:0] I_MULHU = 32'h023130B3;
  localparam logic [31:0] I_MUL   = 32'h023100B3;

  initial begin
    bit accepted;
    bus.IN_VALID = 0; bus.INSTR = 0; bus.PC = 0; bus.RS1_DATA = 0; bus.RS2_DATA = 0;
    bus.OUT_READY = 1;
    #1 RESET = 1'b0;
    #1 cmp_en = 1'b1;
    idle(2);
    check_output("reset_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    check_output("reset_select", {27'd0, bus.SELECT}, 32'd0);
    RESET = 1'b1;
    idle(1);

    // Reset asserted in the middle of a multiply/divide wait.
    apply_stimulus(1'b1, I_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    idle(1);
    #2 RESET = 1'b0;
    #1;
    check_output("async_rst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    check_output("async_rst_data1", bus.DATA1, 32'd0);
    check_output("async_rst_data2", bus.DATA2, 32'd0);
    check_output("async_rst_select", {27'd0, bus.SELECT}, 32'd0);
    @(posedge CLK); #1 RESET = 1'b1;

    apply_stimulus(1'b1, I_ADD, 32'd5, 32'd7, 1'b1, 1'b0);
    check_output("add_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    check_output("add_data1", bus.DATA1, 32'd5);
    check_output("add_data2", bus.DATA2, 32'd7);
    check_output("add_select", {27'd0, bus.SELECT}, 32'd0);

    apply_stimulus(1'b1, I_SRAI, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    check_output("srai_select", {27'd0, bus.SELECT}, 32'd7);
    check_output("srai_data2", bus.DATA2, 32'h0000_0004);
    check_output("srai_data1", bus.DATA1, 32'h8000_0000);
    apply_stimulus(1'b1, I_LUI, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    check_output("lui_data1", bus.DATA1, 32'd0);
    check_output("lui_data2", bus.DATA2, 32'h1234_5000);
    check_output("lui_select", {27'd0, bus.SELECT}, 32'd0);
    idle(1);

    apply_stimulus(1'b1, I_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    check_output("div_wait1_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    check_output("div_wait1_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    idle(1);
    check_output("div_wait2_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    check_output("div_wait2_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    idle(1);
    check_output("div_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    check_output("div_select", {27'd0, bus.SELECT}, 32'h0C);
    check_output("div_data1", bus.DATA1, 32'd100);
    apply_stimulus(1'b1, I_MULHU, 32'd6, 32'd9, 1'b1, 1'b0);
    idle(2);
    check_output("mulhu_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    check_output("mulhu_select", {27'd0, bus.SELECT}, 32'h0A);
    idle(1);

    // Back-pressure with the next instruction waiting upstream.
    apply_stimulus(1'b1, I_ADD, 32'd21, 32'd22, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, I_SUB, 32'd31, 32'd32, 1'b0, 1'b0);
      check_output("stall_data1", bus.DATA1, 32'd21);
      check_output("stall_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    end
    apply_stimulus(1'b1, I_SUB, 32'd31, 32'd32, 1'b1, 1'b0);
    check_output("release_data1", bus.DATA1, 32'd31);
    check_output("release_select", {27'd0, bus.SELECT}, 32'd1);
    check_output("release_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    idle(1);
    check_output("release_drained", {31'd0, bus.OUT_VALID}, 32'd0);

    apply_stimulus(1'b1, I_MUL, 32'd3, 32'd4, 1'b1, 1'b0);
    apply_stimulus(1'b1, I_ADD, 32'd9, 32'd9, 1'b1, 1'b1);
    check_output("flush_wait_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    check_output("flush_wait_in_ready", {31'd0, bus.IN_READY}, 32'd1);
    idle(3);
    check_output("flush_wait_quiet", {31'd0, bus.OUT_VALID}, 32'd0);

    apply_stimulus(1'b1, I_ADD, 32'd11, 32'd12, 1'b0, 1'b0);
    apply_stimulus(1'b1, I_SUB, 32'd13, 32'd14, 1'b1, 1'b1);
    check_output("flush_full_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    idle(2);
    check_output("flush_full_quiet", {31'd0, bus.OUT_VALID}, 32'd0);

    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'd55, 32'd66, 1'b1, 1'b0);
    check_output("illegal_flag", {31'd0, bus.ILLEGAL}, 32'd1);
    check_output("illegal_select", {27'd0, bus.SELECT}, 32'd0);
    check_output("illegal_data1", bus.DATA1, 32'd0);
    check_output("illegal_data2", bus.DATA2, 32'd0);
    check_output("illegal_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    idle(1);

    vecs.push_back('{32'h12345097, 32'h0000_1000, 32'd1, 32'd2});
    vecs.push_back('{32'hFFC12083, 32'h0, 32'h0000_2000, 32'd0});
    vecs.push_back('{32'h00312423, 32'h0, 32'h0000_3000, 32'd77});
    vecs.push_back('{32'h00310063, 32'h0, 32'd40, 32'd41});
    vecs.push_back('{32'hFFF12093, 32'h0, 32'd5, 32'd0});
    vecs.push_back('{32'h023170B3, 32'h0, 32'd17, 32'd5});
    vecs.push_back('{32'h40111093, 32'h0, 32'd8, 32'd9});
    vecs.push_back('{I_SUB, 32'h0, 32'd50, 32'd8});
    vecs.push_back('{32'h023120B3, 32'h0, 32'hFFFF_FFFF, 32'd3});
    vecs.push_back('{32'h403160B3, 32'h0, 32'd1, 32'd1});
    vecs.push_back('{I_ADD, 32'h0, 32'd123, 32'd456});
    foreach (vecs[i]) begin
      accepted = 1'b0;
      for (int w = 0; w < 20 && !accepted; w++) begin
        bus.IN_VALID  = 1'b1;
        bus.INSTR     = vecs[i].ins;
        bus.PC        = vecs[i].pc;
        bus.RS1_DATA  = vecs[i].a;
        bus.RS2_DATA  = vecs[i].b;
        bus.OUT_READY = !((i % 3 == 1) && (w == 0));
        FLUSH         = 1'b0;
        #1 accepted = bus.IN_READY;
        @(posedge CLK);
        #1;
      end
      check_output("vec_accept", {31'd0, accepted}, 32'd1);
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
